// File: rtl/intersection_model_if.sv
// Light colour type plus the traffic-model bus: arrivals and lights in, queue state and checker flags out.
// The slave side is the vehicle model; the master side is whoever drives traffic and lights.
package light_package;
    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } colors;
endpackage

interface intersection_model_if #(
    parameter int QW = 4
);
    logic                ew_str_arrive;
    logic                ew_left_arrive;
    logic                ns_arrive;
    light_package::colors ew_str_light;
    light_package::colors ew_left_light;
    light_package::colors ns_light;
    logic                ew_str_sensor;
    logic                ew_left_sensor;
    logic                ns_sensor;
    logic [QW-1:0]       ew_str_count;
    logic [QW-1:0]       ew_left_count;
    logic [QW-1:0]       ns_count;
    logic                ew_str_depart;
    logic                ew_left_depart;
    logic                ns_depart;
    logic                overflow_err;
    logic                conflict_err;
    logic                yellow_err;
    logic                all_red_err;

    modport master (
        output ew_str_arrive, ew_left_arrive, ns_arrive,
        output ew_str_light, ew_left_light, ns_light,
        input  ew_str_sensor, ew_left_sensor, ns_sensor,
        input  ew_str_count, ew_left_count, ns_count,
        input  ew_str_depart, ew_left_depart, ns_depart,
        input  overflow_err, conflict_err, yellow_err, all_red_err
    );

    modport slave (
        input  ew_str_arrive, ew_left_arrive, ns_arrive,
        input  ew_str_light, ew_left_light, ns_light,
        output ew_str_sensor, ew_left_sensor, ns_sensor,
        output ew_str_count, ew_left_count, ns_count,
        output ew_str_depart, ew_left_depart, ns_depart,
        output overflow_err, conflict_err, yellow_err, all_red_err
    );
endinterface

// File: rtl/intersection_model.sv
// Three-street vehicle queue model with sticky light-sequence checkers for a controller under test.
// Counts/flags update one cycle after inputs; departs are combinational; no backpressure (full queues drop).
module intersection_model #(
    parameter int QW = 4
) (
    input logic                 clk,
    input logic                 reset,
    intersection_model_if.slave bus
);
    import light_package::*;

    localparam logic [QW-1:0] CNT_MAX = '1;

    // Street index: 0 = east-west straight, 1 = east-west left, 2 = north-south.
    colors         light [3];
    colors         prev  [3];
    logic [QW-1:0] cnt   [3];
    logic [1:0]    yrun  [3];
    logic [2:0]    arrive;
    logic [2:0]    depart;
    logic [2:0]    full;
    logic [2:0]    nonred;

    logic overflow_now;
    logic conflict_now;
    logic yellow_now;
    logic all_red_now;

    logic overflow_q;
    logic conflict_q;
    logic yellow_q;
    logic all_red_q;

    assign light[0] = bus.ew_str_light;
    assign light[1] = bus.ew_left_light;
    assign light[2] = bus.ns_light;
    assign arrive   = {bus.ns_arrive, bus.ew_left_arrive, bus.ew_str_arrive};

    always_comb begin
        depart = '0;
        full   = '0;
        nonred = '0;
        for (int i = 0; i < 3; i++) begin
            depart[i] = (light[i] == GREEN) && (cnt[i] != '0);
            full[i]   = (cnt[i] == CNT_MAX);
            nonred[i] = (light[i] != RED);
        end
    end

    assign overflow_now = |(arrive & ~depart & full);
    assign conflict_now = ($countones(nonred) > 1);

    always_comb begin
        yellow_now  = 1'b0;
        all_red_now = 1'b0;
        for (int i = 0; i < 3; i++) begin
            // A proper yellow lasts exactly two cycles; skipping yellow either way is also illegal.
            if ((prev[i] == YELLOW && light[i] != YELLOW && yrun[i] != 2'd2) ||
                (prev[i] == GREEN  && light[i] == RED) ||
                (prev[i] == RED    && light[i] == YELLOW))
                yellow_now = 1'b1;
            if (light[i] == GREEN && prev[i] == RED) begin
                for (int j = 0; j < 3; j++) begin
                    if (j != i && prev[j] == YELLOW)
                        all_red_now = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                cnt[i]  <= '0;
                yrun[i] <= 2'd0;
                prev[i] <= RED;
            end
            overflow_q <= 1'b0;
            conflict_q <= 1'b0;
            yellow_q   <= 1'b0;
            all_red_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (arrive[i] && !depart[i]) begin
                    if (!full[i])
                        cnt[i] <= cnt[i] + 1'b1;
                end else if (depart[i] && !arrive[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
                if (light[i] == YELLOW)
                    yrun[i] <= (yrun[i] == 2'd3) ? 2'd3 : yrun[i] + 2'd1;
                else
                    yrun[i] <= 2'd0;
                prev[i] <= light[i];
            end
            overflow_q <= overflow_q | overflow_now;
            conflict_q <= conflict_q | conflict_now;
            yellow_q   <= yellow_q   | yellow_now;
            all_red_q  <= all_red_q  | all_red_now;
        end
    end

    assign bus.ew_str_count   = cnt[0];
    assign bus.ew_left_count  = cnt[1];
    assign bus.ns_count       = cnt[2];
    assign bus.ew_str_sensor  = (cnt[0] != '0);
    assign bus.ew_left_sensor = (cnt[1] != '0);
    assign bus.ns_sensor      = (cnt[2] != '0);
    assign bus.ew_str_depart  = depart[0];
    assign bus.ew_left_depart = depart[1];
    assign bus.ns_depart      = depart[2];
    assign bus.overflow_err   = overflow_q;
    assign bus.conflict_err   = conflict_q;
    assign bus.yellow_err     = yellow_q;
    assign bus.all_red_err    = all_red_q;
endmodule

// File: tb/tb_intersection_model.sv
// Bench for intersection_model: directed scenarios plus randomized traffic against a queue/history model.
module tb_intersection_model;
    import light_package::*;

    localparam int QW   = 4;
    localparam int MAXC = (1 << QW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    intersection_model_if #(.QW(QW)) bus ();
    intersection_model #(.QW(QW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int errors = 0;
    int checks = 0;

    // stimulus for the current cycle
    bit    arr [3];
    colors lt  [3];
    int    last_dep [3];

    // reference model state
    int    m_cnt  [3];
    colors m_prev [3];
    int    m_ylen [3];
    bit    m_ovf, m_conf, m_yel, m_allred;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int o_cnt(int i);
        case (i)
            0:       return int'(bus.ew_str_count);
            1:       return int'(bus.ew_left_count);
            default: return int'(bus.ns_count);
        endcase
    endfunction

    function automatic int o_sen(int i);
        case (i)
            0:       return int'(bus.ew_str_sensor);
            1:       return int'(bus.ew_left_sensor);
            default: return int'(bus.ns_sensor);
        endcase
    endfunction

    function automatic int o_dep(int i);
        case (i)
            0:       return int'(bus.ew_str_depart);
            1:       return int'(bus.ew_left_depart);
            default: return int'(bus.ns_depart);
        endcase
    endfunction

    function automatic int m_dep(int i);
        return (lt[i] == GREEN && m_cnt[i] > 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]  = 0;
            m_prev[i] = RED;
            m_ylen[i] = 0;
        end
        m_ovf = 0; m_conf = 0; m_yel = 0; m_allred = 0;
    endtask

    task automatic model_edge();
        int d [3];
        int lit;
        lit = 0;
        for (int i = 0; i < 3; i++) d[i] = m_dep(i);
        for (int i = 0; i < 3; i++) begin
            if (arr[i] && d[i] == 0) begin
                if (m_cnt[i] == MAXC) m_ovf = 1;
                else m_cnt[i]++;
            end else if (!arr[i] && d[i] == 1) begin
                m_cnt[i]--;
            end
            if (lt[i] != RED) lit++;
            if (m_prev[i] == YELLOW && lt[i] != YELLOW && m_ylen[i] != 2) m_yel = 1;
            if (m_prev[i] == GREEN && lt[i] == RED) m_yel = 1;
            if (m_prev[i] == RED && lt[i] == YELLOW) m_yel = 1;
            if (lt[i] == GREEN && m_prev[i] == RED)
                for (int j = 0; j < 3; j++)
                    if (j != i && m_prev[j] == YELLOW) m_allred = 1;
        end
        if (lit > 1) m_conf = 1;
        for (int i = 0; i < 3; i++) begin
            m_ylen[i] = (lt[i] == YELLOW) ? m_ylen[i] + 1 : 0;
            m_prev[i] = lt[i];
        end
    endtask

    task automatic drive();
        bus.ew_str_arrive  = arr[0];
        bus.ew_left_arrive = arr[1];
        bus.ns_arrive      = arr[2];
        bus.ew_str_light   = lt[0];
        bus.ew_left_light  = lt[1];
        bus.ns_light       = lt[2];
    endtask

    task automatic set_in(input bit a0, input bit a1, input bit a2,
                          input colors l0, input colors l1, input colors l2);
        arr[0] = a0; arr[1] = a1; arr[2] = a2;
        lt[0]  = l0; lt[1]  = l1; lt[2]  = l2;
    endtask

    task automatic check_state();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("count%0d", i), o_cnt(i), m_cnt[i]);
            chk($sformatf("sensor%0d", i), o_sen(i), (m_cnt[i] != 0) ? 1 : 0);
        end
        chk("overflow_err", int'(bus.overflow_err), int'(m_ovf));
        chk("conflict_err", int'(bus.conflict_err), int'(m_conf));
        chk("yellow_err",   int'(bus.yellow_err),   int'(m_yel));
        chk("all_red_err",  int'(bus.all_red_err),  int'(m_allred));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step();
        drive();
        #1;
        for (int i = 0; i < 3; i++) begin
            last_dep[i] = o_dep(i);
            chk($sformatf("depart%0d", i), last_dep[i], m_dep(i));
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_state();
    endtask

    // Reset asserted between edges; state must clear before the next rising edge.
    task automatic do_reset();
        #2 reset = 1'b0;
        model_reset();
        #1;
        check_state();
        for (int i = 0; i < 3; i++)
            chk($sformatf("rst_depart%0d", i), o_dep(i), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        set_in(0, 0, 0, RED, RED, RED);
        drive();
        model_reset();
        @(negedge clk);
        do_reset();

        // ns queue fills under red
        for (int k = 1; k <= 3; k++) begin
            set_in(0, 0, 1, RED, RED, RED);
            step();
            chk("ns_fill_count", o_cnt(2), k);
            chk("ns_fill_sensor", o_sen(2), 1);
            chk("ns_fill_depart", last_dep[2], 0);
        end
        // ns drains under green
        for (int k = 1; k <= 5; k++) begin
            set_in(0, 0, 0, RED, RED, GREEN);
            step();
            chk("ns_drain_depart", last_dep[2], (k <= 3) ? 1 : 0);
            chk("ns_drain_count", o_cnt(2), (k <= 3) ? 3 - k : 0);
            chk("ns_drain_sensor", o_sen(2), (k < 3) ? 1 : 0);
        end

        // overflow on a full queue
        do_reset();
        for (int k = 0; k < MAXC; k++) begin
            set_in(0, 1, 0, RED, RED, RED);
            step();
        end
        chk("full_count", o_cnt(1), MAXC);
        set_in(0, 1, 0, RED, RED, RED);
        step();
        chk("ovf_count", o_cnt(1), MAXC);
        chk("ovf_flag", int'(bus.overflow_err), 1);

        // full queue with simultaneous arrival and departure does not overflow
        do_reset();
        for (int k = 0; k < MAXC; k++) begin
            set_in(0, 1, 0, RED, RED, RED);
            step();
        end
        set_in(0, 1, 0, RED, GREEN, RED);
        step();
        chk("passthru_count", o_cnt(1), MAXC);
        chk("passthru_ovf", int'(bus.overflow_err), 0);

        // conflicting greens, then sticky through legal cycles
        do_reset();
        set_in(0, 0, 0, GREEN, RED, GREEN);
        step();
        chk("conflict_set", int'(bus.conflict_err), 1);
        for (int k = 0; k < 3; k++) begin
            set_in(0, 0, 0, GREEN, RED, RED);
            step();
            chk("conflict_sticky", int'(bus.conflict_err), 1);
        end

        // short yellow
        do_reset();
        set_in(0, 0, 0, GREEN, RED, RED);  step();
        set_in(0, 0, 0, YELLOW, RED, RED); step();
        set_in(0, 0, 0, RED, RED, RED);    step();
        chk("short_yellow", int'(bus.yellow_err), 1);

        // proper two-cycle yellow
        do_reset();
        set_in(0, 0, 0, GREEN, RED, RED);  step();
        set_in(0, 0, 0, YELLOW, RED, RED); step();
        set_in(0, 0, 0, YELLOW, RED, RED); step();
        set_in(0, 0, 0, RED, RED, RED);    step();
        chk("good_yellow", int'(bus.yellow_err), 0);
        chk("good_allred", int'(bus.all_red_err), 0);

        // green straight after another street's yellow
        do_reset();
        set_in(0, 0, 0, GREEN, RED, RED);  step();
        set_in(0, 0, 0, YELLOW, RED, RED); step();
        set_in(0, 0, 0, YELLOW, RED, RED); step();
        set_in(0, 0, 0, RED, RED, GREEN);  step();
        chk("no_allred_gap", int'(bus.all_red_err), 1);
        chk("no_allred_yel", int'(bus.yellow_err), 0);

        // loaded queues and a flag, then asynchronous reset mid-cycle
        do_reset();
        for (int k = 0; k < 7; k++) begin
            set_in(k < 5, 1, k < 2, RED, RED, RED);
            step();
        end
        chk("load_ew_str", o_cnt(0), 5);
        chk("load_ew_left", o_cnt(1), 7);
        chk("load_ns", o_cnt(2), 2);
        set_in(0, 0, 0, YELLOW, RED, YELLOW);
        step();
        chk("load_conflict", int'(bus.conflict_err), 1);
        do_reset();

        // randomized traffic in reset-separated windows
        for (int w = 0; w < 20; w++) begin
            do_reset();
            for (int c = 0; c < 30; c++) begin
                for (int i = 0; i < 3; i++) begin
                    int r;
                    arr[i] = ($urandom_range(0, 3) != 0);
                    r = $urandom_range(0, 9);
                    if (w % 4 == 0 || r < 6) lt[i] = RED;
                    else if (r < 8)          lt[i] = YELLOW;
                    else                     lt[i] = GREEN;
                end
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/intersection_model.md
INTERSECTION_MODEL -- requirements
Module: intersection_model

Interface
REQ-001 Parameter QW, default 4: width of each per-street vehicle queue counter; queue capacity is 2^QW-1.
REQ-002 clk  in  1  single rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 ew_str_arrive, ew_left_arrive, ns_arrive  in  1 each  one vehicle arrives on that street in this cycle.
REQ-005 ew_str_light, ew_left_light, ns_light  in  colors (light_package)  light values driven by the controller under test.
REQ-006 ew_str_sensor, ew_left_sensor, ns_sensor  out  1 each  vehicle present on that street; these feed the controller's sensor inputs.
REQ-007 ew_str_count, ew_left_count, ns_count  out  QW each  current queue occupancy.
REQ-008 ew_str_depart, ew_left_depart, ns_depart  out  1 each  one vehicle leaves that queue in this cycle.
REQ-009 overflow_err  out  1  sticky flag: an arrival was dropped because a queue was full.
REQ-010 conflict_err  out  1  sticky flag: two or more lights were non-red in the same cycle.
REQ-011 yellow_err  out  1  sticky flag: a yellow-phase rule was violated.
REQ-012 all_red_err  out  1  sticky flag: a green started without an all-red cycle after another street's yellow.

Function
REQ-013 Each street has an independent queue counter; all three streets follow identical rules.
REQ-014 The depart output for a street is combinational and is high when that street's light is green and its count is nonzero.
- At most one vehicle departs per street per cycle.
- No vehicle departs on yellow or red.
REQ-015 The count updates on the clock edge:
- arrive and no depart: count+1.
- depart and no arrive: count-1.
- arrive and depart together: count unchanged.
- neither: count unchanged.
REQ-016 If arrive is high, no depart occurs and count equals 2^QW-1:
- the count holds at 2^QW-1 (no wrap-around);
- overflow_err sets on that edge.
REQ-017 The count never decrements below 0.
REQ-018 Each sensor equals (count != 0), decoded from the registered count.
- An arrival at edge n makes the sensor high in the cycle after edge n.
REQ-019 Light inputs are sampled every clock edge. prev_* registers hold the previous cycle's value of each light.
REQ-020 conflict_err sets on any edge where more than one light input is non-red.
REQ-021 Each street has a yellow-run counter, saturating at 3, that counts consecutive yellow cycles.
REQ-022 yellow_err sets on any of these edges:
- a light leaves yellow with a yellow-run count other than 2;
- a light goes from green directly to red;
- a light goes from red directly to yellow.
REQ-023 all_red_err sets on any edge where:
- a light is green and its prev value was red; and
- any other street's prev light was yellow.
REQ-024 All four error flags are sticky. Only reset clears them.
REQ-025 Simultaneous violations set every applicable flag on the same edge.
REQ-026 Error checking never alters queue behaviour.

Reset
REQ-027 While reset=0, the following hold immediately, with no clock edge required:
- all counts and yellow-run counters are 0;
- all prev_* registers are red;
- all sensors, departs and error flags are 0.
REQ-028 Reset asserted mid-operation discards all queue contents and error history.
REQ-029 The first clock edge after reset=1 is a normal update.

Verification
REQ-030 After reset, ns_arrive=1 for 3 cycles with ns_light=red -> ns_count goes 1,2,3; ns_sensor is high from the cycle after the first edge; ns_depart stays 0.
REQ-031 ns_count=3, ns_light=green for 5 cycles, no arrivals -> ns_depart high for 3 cycles; count goes 2,1,0,0,0; ns_sensor is 0 once count is 0.
REQ-032 QW=4, ew_left_count=15:
- arrival with red light -> count stays 15 and overflow_err=1;
- after reset, count=15 with arrival and green together -> count stays 15 and overflow_err=0.
REQ-033 ew_str_light=green and ns_light=green in one cycle -> conflict_err=1 after that edge and stays 1 through later legal cycles until reset=0.
REQ-034 Yellow-phase sequences:
- ew_str sequence G,Y,R -> yellow_err=1;
- ew_str sequence G,Y,Y,R -> yellow_err=0;
- ew_str sequence G,Y,Y,R then ns_light=green on the cycle directly after the second Y -> all_red_err=1.
REQ-035 Queues at 5/7/2 with conflict_err=1, then reset pulsed low between clock edges -> all counts, sensors and flags read 0 before the next edge.
